// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared constants and pipeline-stage type for data_mem_responder.
// Rev     : 1.0  initial release
// ============================================================================
package dmem_pkg;

  localparam int DMEM_WORD_W         = 16;
  localparam int DMEM_LATENCY_DEF    = 4;
  localparam int DMEM_WORDS_LOG2_DEF = 15;

  typedef struct packed {
    logic                   valid;
    logic [DMEM_WORD_W-1:0] data;
    logic                   err;
  } dmem_stage_t;

endpackage
`default_nettype wire

// File: rtl/dmem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pipe_stage
// Purpose : One holdable response-pipeline register; loads when i_en is high.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_pipe_stage
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  dmem_stage_t i_stage,
  output dmem_stage_t o_stage
);

  dmem_stage_t stage_d;
  dmem_stage_t stage_q;

  always_comb begin
    stage_d = stage_q;
    if (i_en) begin
      stage_d = i_stage;
    end
  end

  // Whole stage is cleared so rsp_rdata reads back zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_stage = stage_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Purpose : Multi-cycle data memory; immediate stores, in-order fixed-latency
//           loads with requester back-pressure.
// Option  : DMEM_ALIGN_CHECK_EN enables misaligned-access flagging.
// Rev     : 1.0  initial release
// ============================================================================
module data_mem_responder #(
  parameter int LATENCY    = dmem_pkg::DMEM_LATENCY_DEF,
  parameter int WORDS_LOG2 = dmem_pkg::DMEM_WORDS_LOG2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  import dmem_pkg::*;

  localparam int DEPTH = 1 << WORDS_LOG2;

  logic [DMEM_WORD_W-1:0] mem [DEPTH];

  dmem_stage_t           stage_link [LATENCY+1];
  dmem_stage_t           stage_in;
  logic                  advance;
  logic                  accept;
  logic                  misaligned;
  logic                  wr_en;
  logic                  load_acc;
  logic [WORDS_LOG2-1:0] word_idx;
  logic                  unused_addr;

  assign word_idx    = req_addr[WORDS_LOG2:1];
  assign unused_addr = ^req_addr;

  // The whole pipeline freezes while the head response waits for rsp_ready.
  assign advance   = ~(stage_link[LATENCY].valid & ~rsp_ready);
  assign req_ready = advance;
  assign accept    = req_valid & advance;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = req_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  assign load_acc = accept & ~req_wr;
  assign wr_en    = accept & req_wr & ~misaligned;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_idx] <= req_wdata;
    end
  end

  always_comb begin
    stage_in       = '0;
    stage_in.valid = load_acc;
    stage_in.err   = load_acc & misaligned;
    if (load_acc & ~misaligned) begin
      stage_in.data = mem[word_idx];
    end
  end

  assign stage_link[0] = stage_in;

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    dmem_pipe_stage u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (advance),
      .i_stage (stage_link[g]),
      .o_stage (stage_link[g+1])
    );
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= LATENCY; k++) begin
      busy = busy | stage_link[k].valid;
    end
  end

  assign rsp_valid = stage_link[LATENCY].valid;
  assign rsp_rdata = stage_link[LATENCY].data;
  assign rsp_err   = stage_link[LATENCY].err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Purpose : Self-checking bench for data_mem_responder (default LATENCY=4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int LAT = 4;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  data_mem_responder #(.LATENCY(LAT), .WORDS_LOG2(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Model: outstanding loads in order, each with the number of pipeline
  // advances still needed before it is presented to the requester.
  typedef struct {
    logic [15:0] data;
    logic        err;
    int          rem;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mmem [int];
  bit          armed = 1'b0;
  bit          pm_v, pm_adv, pm_mis;
  int          pm_w;
  ent_t        pm_e;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      armed = 1'b1;
    end else if (armed) begin
      pm_v   = (mq.size() > 0) && (mq[0].rem == 0);
      pm_adv = !(pm_v && !rsp_ready);
      if (pm_adv) begin
        if (pm_v) void'(mq.pop_front());
        foreach (mq[i]) mq[i].rem = mq[i].rem - 1;
        if (req_valid) begin
          pm_w   = int'(req_addr) / 2;
          pm_mis = ALIGN && req_addr[0];
          if (req_wr) begin
            if (!pm_mis) mmem[pm_w] = req_wdata;
          end else begin
            pm_e.err  = pm_mis;
            pm_e.data = pm_mis ? 16'h0 : (mmem.exists(pm_w) ? mmem[pm_w] : 16'h0);
            pm_e.rem  = LAT - 1;
            mq.push_back(pm_e);
          end
        end
      end
    end
  end

  bit nm_v;
  always @(negedge clk) begin
    if (armed) begin
      nm_v = (mq.size() > 0) && (mq[0].rem == 0);
      check("model rsp_valid", 32'(rsp_valid), 32'(nm_v));
      check("model req_ready", 32'(req_ready), 32'(!(nm_v && !rsp_ready)));
      check("model busy", 32'(busy), 32'(mq.size() > 0));
      if (nm_v) begin
        check("model rsp_rdata", 32'(rsp_rdata), 32'(mq[0].data));
        check("model rsp_err", 32'(rsp_err), 32'(mq[0].err));
      end
    end
  end

  // Popped responses, for order / throughput checks.
  logic [15:0] got_d[$];
  int          got_c[$];
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      got_d.push_back(rsp_rdata);
      got_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit wr, input logic [15:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    step();
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_wr    = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    if (!rsp_valid) check("wait rsp_valid timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_got(input int cnt);
    int k = 0;
    while (got_d.size() < cnt && k < 50) begin
      step();
      k++;
    end
    check("response count", 32'(got_d.size()), 32'(cnt));
  endtask

  int n;

  initial begin
    // Reset for two cycles
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);

    req(1'b1, 16'h0000, 16'h1111);
    req(1'b1, 16'h0002, 16'h2222);
    req(1'b1, 16'h0004, 16'h3333);

    // Store then load next cycle: read-after-write and latency
    req(1'b1, 16'h0010, 16'hBEEF);
    req(1'b0, 16'h0010, 16'h0000);
    idle();
    wait_valid(n);
    check("load latency", 32'(n), 32'(LAT));
    check("raw rdata", 32'(rsp_rdata), 32'h0000BEEF);
    step();

    // Back-to-back loads, full throughput
    got_d.delete(); got_c.delete();
    req(1'b0, 16'h0000, 16'h0);
    req(1'b0, 16'h0002, 16'h0);
    req(1'b0, 16'h0004, 16'h0);
    idle();
    wait_got(3);
    if (got_d.size() == 3) begin
      check("b2b data0", 32'(got_d[0]), 32'h1111);
      check("b2b data1", 32'(got_d[1]), 32'h2222);
      check("b2b data2", 32'(got_d[2]), 32'h3333);
      check("b2b consecutive1", 32'(got_c[1] - got_c[0]), 32'd1);
      check("b2b consecutive2", 32'(got_c[2] - got_c[1]), 32'd1);
    end

    // Same loads with a 5-cycle stall on the first response
    got_d.delete(); got_c.delete();
    req(1'b0, 16'h0000, 16'h0);
    req(1'b0, 16'h0002, 16'h0);
    req(1'b0, 16'h0004, 16'h0);
    rsp_ready = 1'b0;
    idle();
    wait_valid(n);
    for (int k = 0; k < 5; k++) begin
      check("stall rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall rdata held", 32'(rsp_rdata), 32'h1111);
      check("stall req_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    wait_got(3);
    if (got_d.size() == 3) begin
      check("stall data0", 32'(got_d[0]), 32'h1111);
      check("stall data1", 32'(got_d[1]), 32'h2222);
      check("stall data2", 32'(got_d[2]), 32'h3333);
    end
    step();

    // Reset with two loads in flight
    req(1'b0, 16'h0000, 16'h0);
    req(1'b0, 16'h0002, 16'h0);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("post-rst busy", 32'(busy), 32'd0);
      step();
    end
    req(1'b0, 16'h0010, 16'h0);
    idle();
    wait_valid(n);
    check("post-rst load", 32'(rsp_rdata), 32'h0000BEEF);
    step();

    // Misaligned store and loads
    req(1'b1, 16'h0020, 16'h5A5A);
    req(1'b1, 16'h0021, 16'h1234);
    req(1'b0, 16'h0020, 16'h0);
    idle();
    wait_valid(n);
    check("misaligned store effect", 32'(rsp_rdata), ALIGN ? 32'h5A5A : 32'h1234);
    check("aligned load err", 32'(rsp_err), 32'd0);
    step();
    req(1'b0, 16'h0021, 16'h0);
    idle();
    wait_valid(n);
    check("misaligned load err", 32'(rsp_err), ALIGN ? 32'd1 : 32'd0);
    check("misaligned load data", 32'(rsp_rdata), ALIGN ? 32'h0 : 32'h1234);
    step();

    // Mixed stream with intermittent back-pressure, checked by the model
    for (int i = 0; i < 16; i++) begin
      rsp_ready = (i % 3) != 2;
      if (i % 4 == 0) req(1'b1, 16'h0040, 16'hC000 + 16'(i));
      else if (i % 2 == 1) req(1'b0, 16'h0040, 16'h0);
      else req(1'b0, 16'h0003, 16'h0);
    end
    idle();
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) step();
    check("drained busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
